// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite to register-bus bridge.
package axi_lite_pkg;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [1:0]  RESP_SLVERR      = 2'b10;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP
    } bridge_state_t;

    // An address is rejected when it falls outside the window or is not word aligned.
    function automatic logic addr_is_bad(input logic [31:0] addr, input logic [31:0] span);
        return (addr >= span) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/axi_lite_hold_slot.sv
// One-entry holding register for an AXI channel: accepts on valid/ready,
// presents full/data downstream, and empties on consume.
module axi_lite_hold_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         full,
    output logic [W-1:0] data,
    input  logic         consume
);

    logic take;

    assign take = in_valid && in_ready;

    // Occupancy and registered ready; ready is low through reset and while holding a beat.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading the pre-edge values.
        if (rst) begin
            full     <= 1'b0;
            in_ready <= 1'b0;
        end else if (take) begin
            full     <= 1'b1;
            in_ready <= 1'b0;
        end else if (consume) begin
            full     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            in_ready <= !full;
        end
    end

    // Payload capture on handshake.
    always_ff @(posedge clk) begin
        // NOTE: payload has no reset; it is only ever looked at while full is set.
        if (take) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/axi_lite_regbus_bridge.sv
// AXI4-Lite responder that turns each transaction into one req/ack beat on a
// simple register bus, with decode, alignment and timeout errors as SLVERR.
module axi_lite_regbus_bridge
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] REG_SPAN = 32'h10,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        reg_req,
    output logic        reg_we,
    output logic [31:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_wstrb,
    input  logic        reg_ack,
    input  logic [31:0] reg_rdata,
    input  logic        reg_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    bridge_state_t   state;
    logic            last_grant_wr;
    logic [CW-1:0]   cnt;

    logic            aw_full, w_full, ar_full;
    logic [31:0]     aw_addr, ar_addr;
    logic [35:0]     w_word;

    logic            contention, grant_wr, grant_rd, grant_bad, timeout_hit;
    logic            wr_consume, rd_consume;

    axi_lite_hold_slot #(.W(32)) u_aw_slot (
        .clk(clk), .rst(rst), .in_valid(awvalid), .in_ready(awready), .in_data(awaddr),
        .full(aw_full), .data(aw_addr), .consume(wr_consume)
    );

    axi_lite_hold_slot #(.W(36)) u_w_slot (
        .clk(clk), .rst(rst), .in_valid(wvalid), .in_ready(wready), .in_data({wstrb, wdata}),
        .full(w_full), .data(w_word), .consume(wr_consume)
    );

    axi_lite_hold_slot #(.W(32)) u_ar_slot (
        .clk(clk), .rst(rst), .in_valid(arvalid), .in_ready(arready), .in_data(araddr),
        .full(ar_full), .data(ar_addr), .consume(rd_consume)
    );

    // A write needs both address and data; on contention the side not served last time wins.
    assign contention  = aw_full && w_full && ar_full;
    assign grant_wr    = aw_full && w_full && (!ar_full || !last_grant_wr);
    assign grant_rd    = ar_full && !grant_wr;
    assign grant_bad   = addr_is_bad(grant_wr ? aw_addr : ar_addr, REG_SPAN);
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // Slots are released when an erroring grant skips the bus or when the bus beat ends.
    assign wr_consume = ((state == ST_IDLE) && grant_wr && grant_bad) ||
                        ((state == ST_WR_REQ) && (reg_ack || timeout_hit));
    assign rd_consume = ((state == ST_IDLE) && grant_rd && grant_bad) ||
                        ((state == ST_RD_REQ) && (reg_ack || timeout_hit));

    // Bridge FSM with all bus-facing outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            last_grant_wr <= 1'b1;
            cnt           <= '0;
            bvalid        <= 1'b0;
            bresp         <= RESP_OKAY;
            rvalid        <= 1'b0;
            rresp         <= RESP_OKAY;
            rdata         <= '0;
            reg_req       <= 1'b0;
            reg_we        <= 1'b0;
            reg_addr      <= '0;
            reg_wdata     <= '0;
            reg_wstrb     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (grant_wr) begin
                        if (contention) last_grant_wr <= 1'b1;
                        if (grant_bad) begin
                            state  <= ST_WR_RESP;
                            bvalid <= 1'b1;
                            bresp  <= RESP_SLVERR;
                        end else begin
                            state     <= ST_WR_REQ;
                            reg_req   <= 1'b1;
                            reg_we    <= 1'b1;
                            reg_addr  <= aw_addr;
                            reg_wdata <= w_word[31:0];
                            reg_wstrb <= w_word[35:32];
                        end
                    end else if (grant_rd) begin
                        if (contention) last_grant_wr <= 1'b0;
                        if (grant_bad) begin
                            state  <= ST_RD_RESP;
                            rvalid <= 1'b1;
                            rresp  <= RESP_SLVERR;
                            rdata  <= ERR_DATA;
                        end else begin
                            state     <= ST_RD_REQ;
                            reg_req   <= 1'b1;
                            reg_we    <= 1'b0;
                            reg_addr  <= ar_addr;
                            reg_wstrb <= '0;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (reg_ack) begin
                        state   <= ST_WR_RESP;
                        reg_req <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= reg_err ? RESP_SLVERR : RESP_OKAY;
                    end else if (timeout_hit) begin
                        state   <= ST_WR_RESP;
                        reg_req <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= RESP_SLVERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RD_REQ: begin
                    if (reg_ack) begin
                        state   <= ST_RD_RESP;
                        reg_req <= 1'b0;
                        rvalid  <= 1'b1;
                        rresp   <= reg_err ? RESP_SLVERR : RESP_OKAY;
                        rdata   <= reg_err ? ERR_DATA : reg_rdata;
                    end else if (timeout_hit) begin
                        state   <= ST_RD_RESP;
                        reg_req <= 1'b0;
                        rvalid  <= 1'b1;
                        rresp   <= RESP_SLVERR;
                        rdata   <= ERR_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WR_RESP: begin
                    if (bready) begin
                        state  <= ST_IDLE;
                        bvalid <= 1'b0;
                    end
                end
                ST_RD_RESP: begin
                    if (rready) begin
                        state  <= ST_IDLE;
                        rvalid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_regbus_bridge.sv
// Self-checking bench for axi_lite_regbus_bridge: directed scenarios plus
// randomized single transactions against a transaction-level reference model.
module tb_axi_lite_regbus_bridge;

    localparam logic [31:0] SPAN = 32'h10;
    localparam int          TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata, reg_addr, reg_wdata, reg_rdata;
    logic [3:0]  wstrb, reg_wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic        reg_req, reg_we, reg_ack, reg_err;

    int n_checks = 0;
    int n_pass   = 0;

    // downstream responder state
    int          cfg_delay;
    logic        cfg_err;
    logic [31:0] cfg_rdata;
    int          pulses = 0;
    int          unstable = 0;
    int          cur_len = 0;
    int          last_len = 0;
    logic        req_prev = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we;

    axi_lite_regbus_bridge #(.REG_SPAN(SPAN), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register-bus target: acks in the cfg_delay-th request cycle (0 = first), noise otherwise.
    initial begin
        reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reg_req === 1'b1) begin
                if (!req_prev) begin
                    pulses++;
                    cur_len   = 0;
                    cap_addr  = reg_addr;
                    cap_we    = reg_we;
                    cap_wdata = reg_wdata;
                    cap_wstrb = reg_wstrb;
                end else if (reg_addr !== cap_addr || reg_we !== cap_we ||
                             reg_wdata !== cap_wdata || reg_wstrb !== cap_wstrb) begin
                    unstable++;
                end
                cur_len++;
                last_len  = cur_len;
                reg_ack   = (cur_len - 1 == cfg_delay);
                reg_rdata = cfg_rdata;
                reg_err   = cfg_err;
            end else begin
                reg_ack   = 1'($urandom_range(0, 1));
                reg_rdata = $urandom;
                reg_err   = 1'($urandom_range(0, 1));
            end
            req_prev = (reg_req === 1'b1);
        end
    end

    // Transaction-level expectation from address, ack delay and downstream error.
    function automatic void model(input logic [31:0] addr, input int d, input logic err,
                                  input logic [31:0] rd, output logic [1:0] resp,
                                  output logic [31:0] data, output int np, output int len);
        if (addr >= SPAN || (addr % 4) != 0) begin
            resp = 2'b10; data = ERRD; np = 0; len = 0;
        end else if (d >= TO) begin
            resp = 2'b10; data = ERRD; np = 1; len = TO;
        end else begin
            resp = err ? 2'b10 : 2'b00;
            data = err ? ERRD : rd;
            np   = 1;
            len  = d + 1;
        end
    endfunction

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        awaddr = a; awvalid = 1'b1;
        while (!awready && n < 60) begin tick(); n++; end
        check("aw_ready", 64'(awready), 64'(1));
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (!wready && n < 60) begin tick(); n++; end
        check("w_ready", 64'(wready), 64'(1));
        tick();
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 60) begin tick(); n++; end
        check("ar_ready", 64'(arready), 64'(1));
        tick();
        arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int dly,
                            input logic err, input int b_dly);
        logic [1:0]  eresp;
        logic [31:0] edata;
        int enp, elen, p0, lat;
        model(a, dly, err, 32'h0, eresp, edata, enp, elen);
        cfg_delay = dly; cfg_err = err; cfg_rdata = $urandom;
        bready = 1'b0;
        p0 = pulses;
        fork
            begin repeat (aw_dly) tick(); send_aw(a); end
            begin repeat (w_dly) tick(); send_w(d, s); end
        join
        check("wr_no_early_req", 64'(pulses), 64'(p0));
        lat = 0;
        while (!bvalid && lat < 200) begin tick(); lat++; end
        check("wr_bvalid", 64'(bvalid), 64'(1));
        check("wr_bresp", 64'(bresp), 64'(eresp));
        check("wr_pulses", 64'(pulses - p0), 64'(enp));
        if (enp == 1) begin
            check("wr_latency", 64'(lat), 64'(elen + 1));
            check("wr_req_len", 64'(last_len), 64'(elen));
            check("wr_reg_fields", {cap_we, cap_wstrb, cap_addr}, {1'b1, s, a});
            check("wr_reg_wdata", 64'(cap_wdata), 64'(d));
        end
        repeat (b_dly) begin
            tick();
            check("wr_b_hold", {bvalid, bresp}, {1'b1, eresp});
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wr_b_done", 64'(bvalid), 64'(0));
    endtask

    task automatic do_read(input logic [31:0] a, input int dly, input logic err,
                           input logic [31:0] rd, input int r_dly);
        logic [1:0]  eresp;
        logic [31:0] edata;
        int enp, elen, p0, lat;
        model(a, dly, err, rd, eresp, edata, enp, elen);
        cfg_delay = dly; cfg_err = err; cfg_rdata = rd;
        rready = 1'b0;
        p0 = pulses;
        send_ar(a);
        lat = 0;
        while (!rvalid && lat < 200) begin tick(); lat++; end
        check("rd_rvalid", 64'(rvalid), 64'(1));
        check("rd_resp_data", {rresp, rdata}, {eresp, edata});
        check("rd_pulses", 64'(pulses - p0), 64'(enp));
        if (enp == 1) begin
            check("rd_latency", 64'(lat), 64'(elen + 1));
            check("rd_req_len", 64'(last_len), 64'(elen));
            check("rd_reg_fields", {cap_we, cap_addr}, {1'b0, a});
        end
        repeat (r_dly) begin
            tick();
            check("rd_r_hold", {rvalid, rresp, rdata}, {1'b1, eresp, edata});
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rd_r_done", 64'(rvalid), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, n;
        logic [31:0] a;
        int d;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        cfg_delay = 0; cfg_err = 1'b0; cfg_rdata = '0;
        repeat (3) tick();

        // reset state
        check("rst_ctrl", {awready, wready, arready, bvalid, rvalid, reg_req, reg_we, bresp, rresp},
              64'(0));
        check("rst_data", {rdata, reg_addr}, 64'(0));
        check("rst_wdata", {reg_wdata, reg_wstrb}, 64'(0));
        rst = 1'b0;
        tick();
        tick();
        check("rst_release_ready", {awready, wready, arready}, 64'(3'b111));

        // single write, ack in first request cycle
        do_write(32'h0, 32'hA5A5_0000, 4'hF, 0, 0, 0, 1'b0, 0);
        // W arrives three cycles before AW, ack after four cycles
        do_write(32'h8, 32'h1357_9BDF, 4'hF, 3, 0, 4, 1'b0, 1);
        // decode and alignment errors
        do_read(32'h20, 0, 1'b0, 32'h1111_1111, 0);
        do_read(32'h6, 0, 1'b0, 32'h2222_2222, 1);
        do_write(32'h10, 32'h3333_3333, 4'hF, 0, 0, 0, 1'b0, 0);
        // timeout, then a normal read
        do_read(32'h4, 1000, 1'b0, 32'h4444_4444, 0);
        do_read(32'h4, 0, 1'b0, 32'hA5A5_0001, 0);
        // ack on the final allowed cycle wins, one later times out
        do_read(32'hC, TO - 1, 1'b0, 32'h5555_5555, 2);
        do_write(32'hC, 32'h6666_6666, 4'h3, 0, 0, TO, 1'b0, 0);
        // zero strobes forwarded, downstream error reported
        do_write(32'h4, 32'h7777_7777, 4'h0, 1, 0, 0, 1'b0, 0);
        do_read(32'h8, 2, 1'b1, 32'h8888_8888, 0);

        // contention after reset: read first, then write with back-pressured B
        rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
        cfg_delay = 0; cfg_err = 1'b0; cfg_rdata = 32'h1234_5678;
        bready = 1'b0; rready = 1'b0;
        p0 = pulses;
        fork
            send_aw(32'h0);
            send_w(32'hCAFE_0005, 4'hF);
            send_ar(32'hC);
        join
        n = 0;
        while (!rvalid && n < 100) begin tick(); n++; end
        check("arb_rvalid", 64'(rvalid), 64'(1));
        check("arb_read_first", {cap_we, cap_addr}, {1'b0, 32'hC});
        check("arb_read_resp", {rresp, rdata}, {2'b00, 32'h1234_5678});
        check("arb_aw_held", {bvalid, awready, wready}, 64'(0));
        rready = 1'b1; tick(); rready = 1'b0;
        n = 0;
        while (!bvalid && n < 100) begin tick(); n++; end
        check("arb_bvalid", 64'(bvalid), 64'(1));
        check("arb_write_second", {cap_we, cap_addr}, {1'b1, 32'h0});
        check("arb_write_data", 64'(cap_wdata), 64'(32'hCAFE_0005));
        check("arb_pulses", 64'(pulses - p0), 64'(2));
        repeat (5) begin
            tick();
            check("arb_b_hold", {bvalid, bresp}, {1'b1, 2'b00});
        end
        bready = 1'b1; tick(); bready = 1'b0;
        check("arb_b_done", 64'(bvalid), 64'(0));

        // reset in the middle of a write request
        cfg_delay = 1000;
        fork
            send_aw(32'h4);
            send_w(32'h9999_0000, 4'hF);
        join
        n = 0;
        while (!reg_req && n < 20) begin tick(); n++; end
        check("mid_rst_req_seen", 64'(reg_req), 64'(1));
        rst = 1'b1;
        tick();
        check("mid_rst_outputs", {reg_req, awready, wready, arready, bvalid, rvalid}, 64'(0));
        rst = 1'b0;
        tick();
        check("mid_rst_ready", {reg_req, awready, wready, arready}, 64'(4'b0111));
        tick();
        check("mid_rst_no_resp", {bvalid, rvalid}, 64'(0));
        do_write(32'h4, 32'hABCD_0004, 4'hF, 0, 0, 0, 1'b0, 0);

        // randomized single transactions
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = SPAN + 32'($urandom_range(0, 15)) * 4;
                1: a = $urandom | 32'h100;
                2: a = 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(1, 3));
                default: a = 32'($urandom_range(0, 3)) * 4;
            endcase
            d = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), d, ($urandom_range(0, 5) == 0),
                         $urandom_range(0, 3));
            else
                do_read(a, d, ($urandom_range(0, 5) == 0), $urandom, $urandom_range(0, 3));
        end

        check("req_stable", 64'(unstable), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_regbus_bridge.md
Name: axi_lite_regbus_bridge

Overview:
AXI4-Lite responder that terminates the AXI-Lite initiator traffic our benches and masters generate. It converts each transaction into a single-beat request on a simple stallable register bus (req/ack) for downstream register files. It buffers the AW, W and AR channels independently and arbitrates between reads and writes. Decode, misalignment and downstream timeout errors are returned as SLVERR, with read data 32'hDEAD_BEEF.

Parameters:
REG_SPAN, 32'h10, byte size of the valid address window starting at 0; an address >= REG_SPAN is a decode error.
TIMEOUT, 16, maximum cycles reg_req may wait for reg_ack before a forced SLVERR; must be >= 2.
ERR_DATA, 32'hDEAD_BEEF, rdata returned on any read error.

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
awaddr  in  32  write address
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  32  write data
wstrb  in  4  byte strobes
wvalid  in  1  W valid
wready  out  1  W ready
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready
araddr  in  32  read address
arvalid  in  1  AR valid
arready  out  1  AR ready
rdata  out  32  read data
rresp  out  2  read response
rvalid  out  1  R valid
rready  in  1  R ready
reg_req  out  1  downstream request, held until reg_ack or timeout
reg_we  out  1  1=write, 0=read
reg_addr  out  32  byte address (aligned)
reg_wdata  out  32  write data
reg_wstrb  out  4  write strobes
reg_ack  in  1  downstream completion, sampled while reg_req=1
reg_rdata  in  32  read data, valid with reg_ack
reg_err  in  1  downstream error, valid with reg_ack

Behaviour:
- Clock and reset: clk; rst synchronous, active-high.
- Reset values: all outputs are 0, state is IDLE, slots are empty and last_grant is write. In-flight transactions are dropped with no response. An rst that arrives mid-transaction drops reg_req at the next edge.
- Channel slots:
  - AW, W and AR each have a one-entry slot.
  - The ready outputs are registered: xready = slot empty, and is 0 while rst is high.
  - Handshake occurs on xvalid && xready at an edge. The slot fills and xready falls the next cycle.
  - AW and W may arrive in either order or together.
  - Slots keep accepting while the FSM is busy, but they are consumed only from IDLE.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE, write eligibility: a write is eligible when both the AW and W slots are full. A read is eligible when the AR slot is full.
- IDLE, arbitration: if both are eligible, grant the opposite of last_grant, then update last_grant. Otherwise grant whichever is eligible.
- IDLE, error check: a granted address is an error if addr >= REG_SPAN or addr[1:0] != 0. On error:
  - skip *_REQ and go directly to *_RESP with resp 2'b10;
  - rdata = ERR_DATA for reads;
  - reg_req stays low.
- WR_REQ / RD_REQ:
  - reg_req=1; reg_we, reg_addr, reg_wdata and reg_wstrb are driven from the slots and are stable for the whole request.
  - When reg_ack=1 in a cycle, go to *_RESP at the following edge.
  - resp = reg_err ? 2'b10 : 2'b00. rdata = reg_err ? ERR_DATA : reg_rdata.
  - On exit, the consumed slots empty and their xready rises the next cycle.
  - Timeout: a cycle counter runs while in *_REQ. If it reaches TIMEOUT cycles without reg_ack, go to *_RESP with SLVERR (rdata = ERR_DATA). reg_req drops at the same edge.
- WR_RESP / RD_RESP:
  - xvalid=1 with bresp/rresp/rdata held stable until xready; then return to IDLE.
  - Back-to-back transactions are permitted: the next grant is evaluated in the first IDLE cycle.
- Latency, write with reg_ack asserted in the first req cycle:
  - AW/W slots full after edge k.
  - reg_req high in cycle k+1 (IDLE→WR_REQ at edge k+1).
  - bvalid high from edge k+2.
  - Reads have the same latency.
- Error paths:
  - A decode error gives xvalid high one cycle after the grant edge.
  - reg_ack arriving on the same edge as the timeout: the ack wins.
  - reg_ack while reg_req=0 is ignored.
- Write data is passed through with its strobes; strobe merging is the downstream's job. A wstrb of 0 is still forwarded.

Decomposition:
- Package axi_lite_pkg:
  - resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - bridge state enum;
  - default ERR_DATA.
- Sub-module axi_lite_hold_slot: a one-entry parameterised-width holding register with valid/ready in and a full/data/consume interface. It is instantiated three times (AW, W, AR).

Test Plan:
1. Write 0x0 with data 32'hA5A5_0000, wstrb F, and reg_ack in the first req cycle -> one reg_req pulse with reg_we=1, reg_addr=0, reg_wdata=A5A5_0000; bresp=00; bvalid exactly 2 cycles after the AW/W edge.
2. W presented 3 cycles before AW, address 0x8, reg_ack after 4 cycles -> no reg_req until AW is accepted; a single request; bresp=00.
3. Read 0x20 with REG_SPAN=0x10; then read 0x6 -> both give reg_req never high, rresp=10, rdata=DEAD_BEEF.
4. Read 0x4 with reg_ack held low and TIMEOUT=16 -> reg_req high exactly 16 cycles then low; rresp=10; rdata=DEAD_BEEF. A second read with reg_ack, reg_rdata=A5A5_0001 -> rresp=00, rdata=A5A5_0001.
5. AW+W (0x0) and AR (0xC) full together with last_grant=write -> read serviced first, then the write. Hold bready=0 for 5 cycles -> bvalid/bresp stay stable; awready stays low until the write completes.
6. Assert rst during WR_REQ -> next edge reg_req=0, all ready/valid=0; after release, readies return to 1 and a new write to 0x4 completes with bresp=00.
